// File: rtl/calc_hex_digit_sequencer.sv
// Shows an 8-bit result on a single 7-segment digit as a repeating sequence:
// high nibble (dp lit), low nibble, blank gap. Optional: CALC_DISP_SKIP_LEADING_ZERO_EN.
module calc_hex_digit_sequencer #(
  parameter logic [23:0] HOLD_CYCLES = 24'd5000000,
  parameter logic [23:0] GAP_CYCLES  = 24'd2500000,
  parameter int          CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] seg_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHOW_HI, SHOW_LO, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 24'd1);
  localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYCLES - 24'd1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       value_q, value_d;
  logic [7:0]       seg_q, seg_d;
  logic             accept;
  logic             skip_new, skip_old;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // A zero high nibble can bypass SHOW_HI, both on accept and on repeat.
`ifdef CALC_DISP_SKIP_LEADING_ZERO_EN
  assign skip_new = (in_data[7:4] == 4'h0);
  assign skip_old = (value_q[7:4] == 4'h0);
`else
  assign skip_new = 1'b0;
  assign skip_old = 1'b0;
`endif

  assign in_ready = (state_q != SHOW_HI);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign seg_out  = seg_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    if (accept) begin
      value_d = in_data;
      state_d = skip_new ? SHOW_LO : SHOW_HI;
      cnt_d   = HOLD_RELOAD;
    end else begin
      case (state_q)
        SHOW_HI: begin
          if (cnt_q == '0) begin
            state_d = SHOW_LO;
            cnt_d   = HOLD_RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SHOW_LO: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = skip_old ? SHOW_LO : SHOW_HI;
            cnt_d   = HOLD_RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Output is decoded from the next state so the register lines up with it.
    case (state_d)
      SHOW_HI: seg_d = {1'b1, hex7(value_d[7:4])};
      SHOW_LO: seg_d = {1'b0, hex7(value_d[3:0])};
      GAP:     seg_d = 8'h00;
      default: seg_d = 8'h40;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= 8'h00;
      seg_q   <= 8'h40;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      seg_q   <= seg_d;
    end
  end

endmodule
